fft_frame_buffer: RTL



---
 rtl/fft_pkg.sv | 18 +
 rtl/fft_frame_buffer_if.sv | 26 ++
 rtl/frame_bank.sv | 28 ++
 rtl/fft_frame_buffer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types and defaults for the FFT front end: frame buffer state encoding
// and the lane offset helper used to address flat frame buses.
package fft_pkg;

    localparam int SAMPLE_SIZE_DEF = 32;
    localparam int BUFFER_SIZE_DEF = 4;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        FILL_HELD = 2'd1,
        STALL     = 2'd2
    } fill_state_t;

    function automatic int frame_slice(input int j, input int sample_size = SAMPLE_SIZE_DEF);
        return j * sample_size;
    endfunction

endpackage

// File: rtl/fft_frame_buffer_if.sv
// Sample-in / frame-out handshake bundle of the FFT frame buffer.
interface fft_frame_buffer_if
    import fft_pkg::*;
#(
    parameter int sample_size = SAMPLE_SIZE_DEF,
    parameter int buffer_size = BUFFER_SIZE_DEF
);
    logic                                 clear;
    logic signed [sample_size-1:0]        in_sample;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [sample_size*buffer_size-1:0]   frame_out;
    logic                                 frame_valid;
    logic                                 frame_ready;
    logic [$clog2(buffer_size):0]         fill_level;

    modport slave (
        input  clear, in_sample, in_valid, frame_ready,
        output in_ready, frame_out, frame_valid, fill_level
    );

    modport master (
        output clear, in_sample, in_valid, frame_ready,
        input  in_ready, frame_out, frame_valid, fill_level
    );
endinterface

// File: rtl/frame_bank.sv
// One frame worth of sample registers: single write lane, all lanes read in parallel.
module frame_bank
    import fft_pkg::*;
#(
    parameter int sample_size = SAMPLE_SIZE_DEF,
    parameter int buffer_size = BUFFER_SIZE_DEF,
    localparam int AW = $clog2(buffer_size)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [AW-1:0]                      addr,
    input  logic [sample_size-1:0]             data,
    output logic [sample_size*buffer_size-1:0] flat
);
    logic [sample_size*buffer_size-1:0] mem_r;

    // Lane write; clearing on reset keeps the idle output bus at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '0;
        end else if (we) begin
            mem_r[frame_slice(int'(addr), sample_size) +: sample_size] <= data;
        end
    end

    assign flat = mem_r;
endmodule

// File: rtl/fft_frame_buffer.sv
// Ping-pong frame assembler: one bank fills while the other is presented to the FFT.
module fft_frame_buffer
    import fft_pkg::*;
#(
    parameter int sample_size = SAMPLE_SIZE_DEF,
    parameter int buffer_size = BUFFER_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fft_frame_buffer_if.slave     bus
);
    localparam int AW = $clog2(buffer_size);
    localparam int IW = $clog2(buffer_size) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(buffer_size - 1);
    localparam logic [IW-1:0] FULL_IDX = IW'(buffer_size);

    fill_state_t   state_r, state_n;
    logic          wr_sel_r, wr_sel_n;
    logic          rd_sel_r, rd_sel_n;
    logic [IW-1:0] wr_idx_r, wr_idx_n;
    logic          frame_valid_r, frame_valid_n;
    logic          swap_s;
    logic          accept_s, consume_s, last_s, in_ready_s;
    logic          we0_s, we1_s;
    logic [sample_size*buffer_size-1:0] bank0_s, bank1_s;

    assign in_ready_s = (state_r != STALL);
    assign accept_s   = bus.in_valid && in_ready_s;
    assign consume_s  = frame_valid_r && bus.frame_ready;
    assign last_s     = (wr_idx_r == LAST_IDX);
    assign we0_s      = accept_s && !bus.clear && (wr_sel_r == 1'b0);
    assign we1_s      = accept_s && !bus.clear && (wr_sel_r == 1'b1);

    frame_bank #(.sample_size(sample_size), .buffer_size(buffer_size)) u_bank0 (
        .clk(clk), .rst_n(rst_n), .we(we0_s), .addr(wr_idx_r[AW-1:0]),
        .data(bus.in_sample), .flat(bank0_s)
    );

    frame_bank #(.sample_size(sample_size), .buffer_size(buffer_size)) u_bank1 (
        .clk(clk), .rst_n(rst_n), .we(we1_s), .addr(wr_idx_r[AW-1:0]),
        .data(bus.in_sample), .flat(bank1_s)
    );

    // Next-state: clear wins, otherwise a completed bank swaps onto the output
    always_comb begin
        state_n       = state_r;
        wr_sel_n      = wr_sel_r;
        rd_sel_n      = rd_sel_r;
        wr_idx_n      = wr_idx_r;
        frame_valid_n = frame_valid_r;
        swap_s        = 1'b0;
        if (bus.clear) begin
            wr_idx_n      = '0;
            frame_valid_n = 1'b0;
            state_n       = FILL;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s && last_s) begin
                        swap_s  = 1'b1;
                        state_n = FILL_HELD;
                    end else begin
                        wr_idx_n = accept_s ? wr_idx_r + IW'(1) : wr_idx_r;
                    end
                end
                FILL_HELD: begin
                    if (accept_s && last_s) begin
                        if (consume_s) begin
                            swap_s = 1'b1;
                        end else begin
                            wr_idx_n = FULL_IDX;
                            state_n  = STALL;
                        end
                    end else begin
                        wr_idx_n = accept_s ? wr_idx_r + IW'(1) : wr_idx_r;
                        if (consume_s) begin
                            frame_valid_n = 1'b0;
                            state_n       = FILL;
                        end else begin
                            state_n = FILL_HELD;
                        end
                    end
                end
                STALL: begin
                    if (consume_s) begin
                        swap_s  = 1'b1;
                        state_n = FILL_HELD;
                    end else begin
                        state_n = STALL;
                    end
                end
                default: begin
                    state_n       = FILL;
                    wr_idx_n      = '0;
                    frame_valid_n = 1'b0;
                end
            endcase
        end
        if (swap_s) begin
            rd_sel_n      = wr_sel_r;
            wr_sel_n      = ~wr_sel_r;
            wr_idx_n      = '0;
            frame_valid_n = 1'b1;
        end else begin
            rd_sel_n = rd_sel_n;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= FILL;
            wr_sel_r      <= 1'b0;
            rd_sel_r      <= 1'b0;
            wr_idx_r      <= '0;
            frame_valid_r <= 1'b0;
        end else begin
            state_r       <= state_n;
            wr_sel_r      <= wr_sel_n;
            rd_sel_r      <= rd_sel_n;
            wr_idx_r      <= wr_idx_n;
            frame_valid_r <= frame_valid_n;
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.frame_valid = frame_valid_r;
    assign bus.fill_level  = wr_idx_r;
    assign bus.frame_out   = rd_sel_r ? bank1_s : bank0_s;
endmodule
